// File: rtl/ysyx_040978_mem_arbiter_pkg.sv
// Shared constants for the IFU/LSU memory arbiter: FSM state encoding and master IDs.
package ysyx_040978_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam logic MID_IFU = 1'b0;
  localparam logic MID_LSU = 1'b1;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    REQ  = ST_REQ,
    WAIT = ST_WAIT
  } state_e;

endpackage

// File: rtl/ysyx_040978_mem_arbiter_rr_pick.sv
// Two-way round-robin pick: a lone requester always wins; on contention the
// pointer names the winner. grant_o is one-hot or zero.
module ysyx_040978_rr_pick
  import ysyx_040978_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  output logic [1:0] grant_o,
  output logic       gid_o
);

  always_comb begin
    grant_o = valid_i;
    if (&valid_i) begin
      grant_o = (ptr_i == MID_LSU) ? 2'b10 : 2'b01;
    end
  end

  assign gid_o = grant_o[1] ? MID_LSU : MID_IFU;

endmodule

// File: rtl/ysyx_040978_mem_arbiter.sv
// Single-outstanding IFU/LSU arbiter onto one memory port (IDLE -> REQ -> WAIT).
// Optional WAIT timeout with error response when YSYX_040978_ARB_TIMEOUT_EN is defined.
module ysyx_040978_mem_arbiter
  import ysyx_040978_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
`ifdef YSYX_040978_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 255
`endif
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                m0_req_valid_i,
  output logic                m0_req_ready_o,
  input  logic [ADDR_W-1:0]   m0_req_addr_i,
  input  logic                m0_req_wen_i,
  input  logic [DATA_W-1:0]   m0_req_wdata_i,
  input  logic [DATA_W/8-1:0] m0_req_wmask_i,
  output logic                m0_resp_valid_o,
  output logic [DATA_W-1:0]   m0_resp_rdata_o,
  output logic                m0_resp_err_o,
  input  logic                m1_req_valid_i,
  output logic                m1_req_ready_o,
  input  logic [ADDR_W-1:0]   m1_req_addr_i,
  input  logic                m1_req_wen_i,
  input  logic [DATA_W-1:0]   m1_req_wdata_i,
  input  logic [DATA_W/8-1:0] m1_req_wmask_i,
  output logic                m1_resp_valid_o,
  output logic [DATA_W-1:0]   m1_resp_rdata_o,
  output logic                m1_resp_err_o,
  output logic                s_req_valid_o,
  input  logic                s_req_ready_i,
  output logic [ADDR_W-1:0]   s_req_addr_o,
  output logic                s_req_wen_o,
  output logic [DATA_W-1:0]   s_req_wdata_o,
  output logic [DATA_W/8-1:0] s_req_wmask_o,
  input  logic                s_resp_valid_i,
  input  logic [DATA_W-1:0]   s_resp_rdata_i,
  input  logic                s_resp_err_i
);

  localparam int MASK_W = DATA_W / 8;

  state_e              state_q, state_d;
  logic                ptr_q, ptr_d;
  logic                gid_q, gid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic [1:0]          rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [1:0]          req_valid;
  logic [1:0]          grant;
  logic                pick_gid;

`ifdef YSYX_040978_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  assign req_valid = {m1_req_valid_i, m0_req_valid_i};

  ysyx_040978_rr_pick u_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .gid_o   (pick_gid)
  );

  // Ready is combinational, so it is masked by reset to keep outputs quiet during reset.
  assign m0_req_ready_o  = ~reset_i & (state_q == IDLE) & grant[0];
  assign m1_req_ready_o  = ~reset_i & (state_q == IDLE) & grant[1];
  assign s_req_valid_o   = (state_q == REQ);
  assign s_req_addr_o    = addr_q;
  assign s_req_wen_o     = wen_q;
  assign s_req_wdata_o   = wdata_q;
  assign s_req_wmask_o   = wmask_q;
  assign m0_resp_valid_o = rsp_valid_q[0];
  assign m1_resp_valid_o = rsp_valid_q[1];
  assign m0_resp_rdata_o = rsp_rdata_q;
  assign m1_resp_rdata_o = rsp_rdata_q;
  assign m0_resp_err_o   = rsp_err_q;
  assign m1_resp_err_o   = rsp_err_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gid_d       = gid_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef YSYX_040978_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (|grant) begin
          gid_d = pick_gid;
          if (pick_gid == MID_LSU) begin
            addr_d  = m1_req_addr_i;
            wen_d   = m1_req_wen_i;
            wdata_d = m1_req_wdata_i;
            wmask_d = m1_req_wmask_i;
          end else begin
            addr_d  = m0_req_addr_i;
            wen_d   = m0_req_wen_i;
            wdata_d = m0_req_wdata_i;
            wmask_d = m0_req_wmask_i;
          end
          state_d = REQ;
        end
      end
      REQ: begin
        if (s_req_ready_i) begin
          state_d = WAIT;
`ifdef YSYX_040978_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      WAIT: begin
        // A real response takes precedence over a timeout landing in the same cycle.
        if (s_resp_valid_i) begin
          rsp_valid_d = (gid_q == MID_LSU) ? 2'b10 : 2'b01;
          rsp_rdata_d = wen_q ? '0 : s_resp_rdata_i;
          rsp_err_d   = s_resp_err_i;
          ptr_d       = ~gid_q;
          state_d     = IDLE;
        end
`ifdef YSYX_040978_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT)) begin
          rsp_valid_d = (gid_q == MID_LSU) ? 2'b10 : 2'b01;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          ptr_d       = ~gid_q;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      gid_q       <= 1'b0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef YSYX_040978_ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gid_q       <= gid_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef YSYX_040978_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_ysyx_040978_mem_arbiter.sv
// Bench for ysyx_040978_mem_arbiter: transaction-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_ysyx_040978_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_valid = 0, m1_valid = 0, m0_ready, m1_ready;
  logic [31:0] m0_addr = 0, m1_addr = 0;
  logic        m0_wen = 0, m1_wen = 0;
  logic [63:0] m0_wdata = 0, m1_wdata = 0;
  logic [7:0]  m0_wmask = 0, m1_wmask = 0;
  logic        m0_rvalid, m1_rvalid, m0_rerr, m1_rerr;
  logic [63:0] m0_rdata, m1_rdata;
  logic        s_valid, s_ready = 0;
  logic [31:0] s_addr;
  logic        s_wen;
  logic [63:0] s_wdata;
  logic [7:0]  s_wmask;
  logic        s_rvalid = 0, s_rerr = 0;
  logic [63:0] s_rdata = 0;

`ifdef YSYX_040978_ARB_TIMEOUT_EN
  localparam int TO = 4;
`endif

  always #5 clk = ~clk;

  ysyx_040978_mem_arbiter #(
    .ADDR_W(32),
    .DATA_W(64)
`ifdef YSYX_040978_ARB_TIMEOUT_EN
    ,
    .TIMEOUT(TO)
`endif
  ) dut (
    .clock_i(clk), .reset_i(rst),
    .m0_req_valid_i(m0_valid), .m0_req_ready_o(m0_ready), .m0_req_addr_i(m0_addr),
    .m0_req_wen_i(m0_wen), .m0_req_wdata_i(m0_wdata), .m0_req_wmask_i(m0_wmask),
    .m0_resp_valid_o(m0_rvalid), .m0_resp_rdata_o(m0_rdata), .m0_resp_err_o(m0_rerr),
    .m1_req_valid_i(m1_valid), .m1_req_ready_o(m1_ready), .m1_req_addr_i(m1_addr),
    .m1_req_wen_i(m1_wen), .m1_req_wdata_i(m1_wdata), .m1_req_wmask_i(m1_wmask),
    .m1_resp_valid_o(m1_rvalid), .m1_resp_rdata_o(m1_rdata), .m1_resp_err_o(m1_rerr),
    .s_req_valid_o(s_valid), .s_req_ready_i(s_ready), .s_req_addr_o(s_addr),
    .s_req_wen_o(s_wen), .s_req_wdata_o(s_wdata), .s_req_wmask_o(s_wmask),
    .s_resp_valid_i(s_rvalid), .s_resp_rdata_i(s_rdata), .s_resp_err_i(s_rerr)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The transaction in flight, the master served last (the other one wins a tie),
  // and the response pulse due in the current cycle.
  typedef struct packed {
    logic        id;
    logic [31:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } txn_t;

  bit          m_ok = 0;
  bit          m_busy = 0;
  bit          m_sent = 0;
  logic        m_last = 1'b1;
  txn_t        m_cur = '0;
  logic [1:0]  m_pulse = 2'b00;
  logic [63:0] m_rdata = '0;
  logic        m_err = 1'b0;
  int          m_waited = 0;
  logic [1:0]  m_g;

  function automatic logic [1:0] model_grant(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return last ? 2'b01 : 2'b10;
    return {v1, v0};
  endfunction

  always @(negedge clk) begin
    m_g = model_grant(m0_valid, m1_valid, m_last);
    if (m_ok) begin
      chk("m0_req_ready", m0_ready, !rst && !m_busy && m_g[0]);
      chk("m1_req_ready", m1_ready, !rst && !m_busy && m_g[1]);
      chk("s_req_valid", s_valid, m_busy && !m_sent);
      chk("s_req_addr", s_addr, m_cur.addr);
      chk("s_req_wen", s_wen, m_cur.wen);
      chk("s_req_wdata", s_wdata, m_cur.wdata);
      chk("s_req_wmask", s_wmask, m_cur.wmask);
      chk("m0_resp_valid", m0_rvalid, m_pulse[0]);
      chk("m1_resp_valid", m1_rvalid, m_pulse[1]);
      if (m_pulse[0]) begin
        chk("m0_resp_rdata", m0_rdata, m_rdata);
        chk("m0_resp_err", m0_rerr, m_err);
      end
      if (m_pulse[1]) begin
        chk("m1_resp_rdata", m1_rdata, m_rdata);
        chk("m1_resp_err", m1_rerr, m_err);
      end
    end
    if (rst) begin
      m_ok = 1; m_busy = 0; m_sent = 0; m_last = 1'b1; m_cur = '0;
      m_pulse = 2'b00; m_rdata = '0; m_err = 1'b0; m_waited = 0;
    end else begin
      m_pulse = 2'b00;
      if (!m_busy) begin
        if (m_g[1]) begin
          m_cur = '{id: 1'b1, addr: m1_addr, wen: m1_wen, wdata: m1_wdata, wmask: m1_wmask};
          m_busy = 1; m_sent = 0;
        end else if (m_g[0]) begin
          m_cur = '{id: 1'b0, addr: m0_addr, wen: m0_wen, wdata: m0_wdata, wmask: m0_wmask};
          m_busy = 1; m_sent = 0;
        end
      end else if (!m_sent) begin
        if (s_ready) begin
          m_sent = 1; m_waited = 0;
        end
      end else if (s_rvalid) begin
        m_pulse[m_cur.id] = 1'b1;
        m_rdata = m_cur.wen ? 64'd0 : s_rdata;
        m_err = s_rerr;
        m_last = m_cur.id;
        m_busy = 0;
      end
`ifdef YSYX_040978_ARB_TIMEOUT_EN
      else if (m_waited == TO) begin
        m_pulse[m_cur.id] = 1'b1;
        m_rdata = 64'd0;
        m_err = 1'b1;
        m_last = m_cur.id;
        m_busy = 0;
      end else begin
        m_waited++;
      end
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) step();
    rst = 0;
    @(negedge clk);
    chk("rst_s_valid", s_valid, 1'b0);
    chk("rst_s_addr", s_addr, 64'd0);
    chk("rst_m0_rvalid", m0_rvalid, 1'b0);
    chk("rst_m0_rdata", m0_rdata, 64'd0);

    // single read from m0
    step(); m0_valid = 1; m0_addr = 32'h8000_0000; m0_wen = 0;
    @(negedge clk);
    chk("t1_ready0", m0_ready, 1'b1);
    chk("t1_ready1", m1_ready, 1'b0);
    step(); m0_valid = 0; s_ready = 1;
    @(negedge clk);
    chk("t1_s_valid", s_valid, 1'b1);
    chk("t1_s_addr", s_addr, 64'h8000_0000);
    step(); s_ready = 0;
    step(); s_rvalid = 1; s_rdata = 64'hDEAD_BEEF_0000_0001;
    step(); s_rvalid = 0; s_rdata = 0;
    @(negedge clk);
    chk("t1_m0_rvalid", m0_rvalid, 1'b1);
    chk("t1_m0_rdata", m0_rdata, 64'hDEAD_BEEF_0000_0001);
    chk("t1_m1_rvalid", m1_rvalid, 1'b0);
    step();
    @(negedge clk);
    chk("t1_pulse_end", m0_rvalid, 1'b0);

    // contention from reset: m0 reads, m1 writes
    step(); rst = 1;
    step(); rst = 0;
    m0_valid = 1; m0_addr = 32'h1000; m0_wen = 0;
    m1_valid = 1; m1_addr = 32'h2000; m1_wen = 1;
    m1_wdata = 64'h1122_3344_5566_7788; m1_wmask = 8'hF0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("t2_prev_resp", (i % 2 == 1) ? m0_rvalid : m1_rvalid, 1'b1);
      end
      chk("t2_ready0", m0_ready, (i % 2 == 0));
      chk("t2_ready1", m1_ready, (i % 2 == 1));
      step(); s_ready = 1;
      @(negedge clk);
      chk("t2_s_addr", s_addr, (i % 2 == 0) ? 64'h1000 : 64'h2000);
      step(); s_ready = 0; s_rvalid = 1; s_rdata = 64'hA0 + 64'(i);
      step(); s_rvalid = 0;
      if (i == 3) begin
        m0_valid = 0; m1_valid = 0;
      end
    end
    @(negedge clk);
    chk("t2_last_m1_rvalid", m1_rvalid, 1'b1);
    chk("t2_write_rdata", m1_rdata, 64'd0);

    // slave stall with m1 waiting
    step(); m0_valid = 1; m0_addr = 32'h3000; m1_valid = 1; m1_addr = 32'h4000; m1_wen = 0;
    @(negedge clk);
    chk("t3_ready0", m0_ready, 1'b1);
    step(); m0_valid = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("t3_stall_addr", s_addr, 64'h3000);
      chk("t3_stall_valid", s_valid, 1'b1);
      chk("t3_no_grant1", m1_ready, 1'b0);
      step();
    end
    s_ready = 1;
    step(); s_ready = 0;
    @(negedge clk);
    chk("t3_wait_grant1", m1_ready, 1'b0);
    step();
    step(); s_rvalid = 1; s_rdata = 64'h33;
    step(); s_rvalid = 0;
    @(negedge clk);
    chk("t3_m0_rvalid", m0_rvalid, 1'b1);
    chk("t3_same_cycle_grant1", m1_ready, 1'b1);
    step(); m1_valid = 0; s_ready = 1;
    step(); s_ready = 0; s_rvalid = 1; s_rerr = 1; s_rdata = 64'h44;
    step(); s_rvalid = 0; s_rerr = 0;
    @(negedge clk);
    chk("t3_m1_rvalid", m1_rvalid, 1'b1);
    chk("t3_m1_err", m1_rerr, 1'b1);
    chk("t3_m1_rdata", m1_rdata, 64'h44);

    // reset in WAIT: first make m0 the last served, so a tie would favour m1 without reset
    step(); m0_valid = 1; m0_addr = 32'h5000;
    step(); m0_valid = 0; s_ready = 1;
    step(); s_ready = 0; s_rvalid = 1; s_rdata = 64'h50;
    step(); s_rvalid = 0;
    step(); m0_valid = 1; m0_addr = 32'h5008;
    step(); m0_valid = 0; s_ready = 1;
    step(); s_ready = 0;
    step(); rst = 1;
    step(); rst = 0; s_rvalid = 1; s_rdata = 64'h55;
    @(negedge clk);
    chk("t4_s_valid", s_valid, 1'b0);
    chk("t4_s_addr", s_addr, 64'd0);
    chk("t4_m0_rvalid", m0_rvalid, 1'b0);
    chk("t4_m1_rvalid", m1_rvalid, 1'b0);
    step(); s_rvalid = 0;
    m0_valid = 1; m0_addr = 32'h5010; m1_valid = 1; m1_addr = 32'h5018;
    @(negedge clk);
    chk("t4_stale_ignored", m0_rvalid, 1'b0);
    chk("t4_ptr_ready0", m0_ready, 1'b1);
    chk("t4_ptr_ready1", m1_ready, 1'b0);
    step(); m0_valid = 0; m1_valid = 0; s_ready = 1;
    step(); s_ready = 0; s_rvalid = 1; s_rdata = 64'h66;
    step(); s_rvalid = 0;
    @(negedge clk);
    chk("t4_m0_rvalid", m0_rvalid, 1'b1);
    chk("t4_m0_rdata", m0_rdata, 64'h66);

`ifdef YSYX_040978_ARB_TIMEOUT_EN
    // slave never answers
    step(); m0_valid = 1; m0_addr = 32'h6000;
    step(); m0_valid = 0; s_ready = 1;
    step(); s_ready = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_no_early_resp", m0_rvalid, 1'b0);
      step();
    end
    @(negedge clk);
    chk("t5_timeout_rvalid", m0_rvalid, 1'b1);
    chk("t5_timeout_err", m0_rerr, 1'b1);
    chk("t5_timeout_rdata", m0_rdata, 64'd0);

    // response coincides with the timeout cycle
    step(); m0_valid = 1; m0_addr = 32'h7000;
    step(); m0_valid = 0; s_ready = 1;
    step(); s_ready = 0;
    repeat (4) step();
    s_rvalid = 1; s_rerr = 0; s_rdata = 64'h77;
    step(); s_rvalid = 0;
    @(negedge clk);
    chk("t6_race_rvalid", m0_rvalid, 1'b1);
    chk("t6_race_err", m0_rerr, 1'b0);
    chk("t6_race_rdata", m0_rdata, 64'h77);
`endif

    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
